// File: rtl/pe_pkg.sv
// Shared PE definitions: sequencer states, default widths and control-word field layout.
package pe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

  localparam int unsigned DEF_CTRL_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  // Control word layout: {out[9:8], op1[7:5], op2[4:2], opcode[1:0]}
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 1;
  localparam int unsigned OP2_LSB = 2;
  localparam int unsigned OP2_MSB = 4;
  localparam int unsigned OP1_LSB = 5;
  localparam int unsigned OP1_MSB = 7;
  localparam int unsigned OUT_LSB = 8;
  localparam int unsigned OUT_MSB = 9;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] SEL_E    = 3'd0;
  localparam logic [2:0] SEL_S    = 3'd1;
  localparam logic [2:0] SEL_W    = 3'd2;
  localparam logic [2:0] SEL_N    = 3'd3;
  localparam logic [2:0] SEL_REG1 = 3'd4;
  localparam logic [2:0] SEL_REG2 = 3'd5;
  localparam logic [2:0] SEL_MEM  = 3'd6;

  function automatic logic [DEF_CTRL_WIDTH-1:0] pack_ctrl(input logic [1:0] out_sel,
                                                          input logic [2:0] op1_sel,
                                                          input logic [2:0] op2_sel,
                                                          input logic [1:0] opcode);
    return {out_sel, op1_sel, op2_sel, opcode};
  endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context store: one synchronous write port, one combinational read port. Not reset.
module pe_ctx_mem
  import pe_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [CTRL_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [CTRL_WIDTH-1:0] o_rdata
);

  logic [CTRL_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Replays context entries 0..ctx_last for iter_count iterations as PE control words,
// honouring stall back-pressure, then pulses done.
module pe_ctx_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ITER_WIDTH = 8,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [CTRL_WIDTH-1:0] cfg_data,
  output logic                  cfg_rej,
  input  logic                  start,
  input  logic [AW-1:0]         ctx_last,
  input  logic [ITER_WIDTH-1:0] iter_count,
  input  logic                  stall,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  ctrl_valid,
  output logic [ITER_WIDTH-1:0] iter_idx,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            r_state;
  logic [AW-1:0]         r_pc;
  logic [AW-1:0]         r_ctx_last;
  logic [ITER_WIDTH-1:0] r_iter_cnt;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_iter_out;
  logic                  r_fin;
  logic [CTRL_WIDTH-1:0] r_ctrl_out;
  logic                  r_ctrl_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_rej;
  logic [CTRL_WIDTH-1:0] w_rd_data;
  logic                  w_mem_we;

  assign w_mem_we = cfg_we && (r_state == StIdle);

  pe_ctx_mem #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (r_pc),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_pc         <= '0;
      r_ctx_last   <= '0;
      r_iter_cnt   <= '0;
      r_iter       <= '0;
      r_iter_out   <= '0;
      r_fin        <= 1'b0;
      r_ctrl_out   <= '0;
      r_ctrl_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_rej    <= 1'b0;
    end else begin
      r_cfg_rej    <= cfg_we && (r_state != StIdle);
      r_done       <= 1'b0;
      r_ctrl_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_ctx_last <= ctx_last;
            r_iter_cnt <= iter_count;
            r_pc       <= '0;
            r_iter     <= '0;
            r_iter_out <= '0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b1;
            if (iter_count == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          // r_fin holds off done for one cycle so it follows the last word.
          if (r_fin) begin
            r_fin   <= 1'b0;
            r_state <= StDone;
            r_done  <= 1'b1;
          end else if (!stall) begin
            r_ctrl_out   <= w_rd_data;
            r_ctrl_valid <= 1'b1;
            r_iter_out   <= r_iter;
            if (r_pc != r_ctx_last) begin
              r_pc <= r_pc + AW'(1);
            end else if (r_iter == r_iter_cnt - ITER_WIDTH'(1)) begin
              r_fin <= 1'b1;
            end else begin
              r_pc   <= '0;
              r_iter <= r_iter + ITER_WIDTH'(1);
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_out   = r_ctrl_out;
  assign ctrl_valid = r_ctrl_valid;
  assign iter_idx   = r_iter_out;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_rej    = r_cfg_rej;

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Bench for pe_ctx_sequencer: directed scenarios plus randomized runs against a word-list model.
module tb_pe_ctx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [9:0] cfg_data;
  logic       cfg_rej;
  logic       start;
  logic [3:0] ctx_last;
  logic [7:0] iter_count;
  logic       stall;
  logic [9:0] ctrl_out;
  logic       ctrl_valid;
  logic [7:0] iter_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [9:0] m_mem [16];
  logic [9:0] last_out;
  int         last_idx;

  pe_ctx_sequencer #(
    .CTRL_WIDTH (10),
    .DEPTH      (16),
    .ITER_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_rej    (cfg_rej),
    .start      (start),
    .ctx_last   (ctx_last),
    .iter_count (iter_count),
    .stall      (stall),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .iter_idx   (iter_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [9:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = data;
    step();
    cfg_we = 1'b0;
    m_mem[addr] = data;
    chk("cfg_rej_idle_write", {31'd0, cfg_rej}, 32'd0);
  endtask

  // Full run: expected word stream is the flat list mem[0..cl] repeated ic times.
  task automatic run(input int cl, input int ic, input int pct, input int sa, input int sl,
                     input bit poke_cfg, input bit poke_start, input bit wr_same,
                     input logic [9:0] wr_val);
    logic [9:0] q_w [$];
    int         q_i [$];
    int         issued = 0;
    int         stall_run = 0;
    int         n = 0;
    bit         st, forced, poked;
    logic [9:0] w;
    int         ix;
    if (wr_same) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'd0;
      cfg_data = wr_val;
    end
    start      = 1'b1;
    ctx_last   = 4'(cl);
    iter_count = 8'(ic);
    step();
    start  = 1'b0;
    cfg_we = 1'b0;
    if (wr_same) m_mem[0] = wr_val;
    for (int it = 0; it < ic; it++) begin
      for (int e = 0; e <= cl; e++) begin
        q_w.push_back(m_mem[e]);
        q_i.push_back(it);
      end
    end
    last_idx = 0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("cfg_rej_at_start", {31'd0, cfg_rej}, 32'd0);
    if (ic == 0) begin
      chk("done_zero_iter", {31'd0, done}, 32'd1);
      chk("valid_zero_iter", {31'd0, ctrl_valid}, 32'd0);
      step();
      chk("done_clear_zero_iter", {31'd0, done}, 32'd0);
      chk("busy_clear_zero_iter", {31'd0, busy}, 32'd0);
      chk("valid_after_zero_iter", {31'd0, ctrl_valid}, 32'd0);
      return;
    end
    chk("done_low_after_start", {31'd0, done}, 32'd0);
    chk("valid_low_after_start", {31'd0, ctrl_valid}, 32'd0);
    while (q_w.size() > 0 && n < 2000) begin
      forced = (issued == sa) && (stall_run < sl);
      if (forced) stall_run++;
      st    = forced || ($urandom_range(99) < pct);
      stall = st;
      poked = poke_cfg && (n == 2);
      if (poked) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'd1;
        cfg_data = 10'h3FF;
      end
      if (poke_start && n == 3) begin
        start      = 1'b1;
        ctx_last   = 4'd2;
        iter_count = 8'd7;
      end
      step();
      n++;
      cfg_we = 1'b0;
      start  = 1'b0;
      chk("cfg_rej_run", {31'd0, cfg_rej}, {31'd0, poked});
      chk("done_mid_run", {31'd0, done}, 32'd0);
      chk("busy_mid_run", {31'd0, busy}, 32'd1);
      if (st) begin
        chk("valid_stalled", {31'd0, ctrl_valid}, 32'd0);
        chk("out_hold_stalled", {22'd0, ctrl_out}, {22'd0, last_out});
        chk("idx_hold_stalled", {24'd0, iter_idx}, 32'(last_idx));
      end else begin
        w  = q_w.pop_front();
        ix = q_i.pop_front();
        chk("valid_issue", {31'd0, ctrl_valid}, 32'd1);
        chk("ctrl_word", {22'd0, ctrl_out}, {22'd0, w});
        chk("iter_idx", {24'd0, iter_idx}, 32'(ix));
        last_out = w;
        last_idx = ix;
        issued++;
      end
    end
    stall = 1'b0;
    chk("word_budget", 32'(q_w.size()), 32'd0);
    step();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("valid_at_done", {31'd0, ctrl_valid}, 32'd0);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    step();
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("valid_idle", {31'd0, ctrl_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    int n;
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    start      = 1'b0;
    ctx_last   = '0;
    iter_count = '0;
    stall      = 1'b0;
    last_out   = '0;
    last_idx   = 0;
    step();
    step();
    chk("rst_ctrl_out", {22'd0, ctrl_out}, 32'd0);
    chk("rst_valid", {31'd0, ctrl_valid}, 32'd0);
    chk("rst_iter_idx", {24'd0, iter_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_rej", {31'd0, cfg_rej}, 32'd0);
    rst = 1'b0;
    step();

    for (int a = 0; a < 16; a++) wr(a, 10'($urandom));
    wr(0, 10'h001);
    wr(1, 10'h002);
    wr(2, 10'h003);
    wr(3, 10'h004);

    // Basic 4x2 run, then the same with a 3-cycle stall after the 2nd word.
    run(3, 2, 0, -1, 0, 1'b0, 1'b0, 1'b0, 10'h0);
    run(3, 2, 0, 2, 3, 1'b0, 1'b0, 1'b0, 10'h0);
    // Zero iterations.
    run(3, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 10'h0);
    // Rejected write mid-run, then a rerun shows entry 1 untouched.
    run(3, 2, 0, -1, 0, 1'b1, 1'b0, 1'b0, 10'h0);
    run(3, 1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 10'h0);
    // Single-entry context with a mid-run start that must be ignored.
    wr(0, 10'h155);
    run(0, 5, 0, -1, 0, 1'b0, 1'b1, 1'b0, 10'h0);
    // Write in the same cycle as start lands before the first read.
    run(2, 2, 0, -1, 0, 1'b0, 1'b0, 1'b1, 10'h001);

    // Reset after the 3rd word of an 8-word run.
    start      = 1'b1;
    ctx_last   = 4'd3;
    iter_count = 8'd2;
    step();
    start = 1'b0;
    cnt   = 0;
    n     = 0;
    while (cnt < 3 && n < 50) begin
      step();
      n++;
      if (ctrl_valid) cnt++;
    end
    chk("pre_reset_words", 32'(cnt), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ctrl_out", {22'd0, ctrl_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, ctrl_valid}, 32'd0);
    chk("mid_rst_iter_idx", {24'd0, iter_idx}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    last_out = '0;
    last_idx = 0;
    step();
    chk("post_rst_no_done", {31'd0, done}, 32'd0);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run(3, 2, 0, -1, 0, 1'b0, 1'b0, 1'b0, 10'h0);

    // Randomized runs over fresh contents, random lengths and random stalls.
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < 16; a++) wr(a, 10'($urandom));
      run(int'($urandom_range(15)), int'($urandom_range(4)), int'($urandom_range(50)),
          int'($urandom_range(6)), int'($urandom_range(3)), 1'($urandom), 1'($urandom),
          1'($urandom), 10'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_ctx_sequencer.md
# pe_ctx_sequencer

Context sequencer that drives the `ctrl` word of one PE (or a broadcast group of PEs). Software preloads up to `DEPTH` context words, each an output/op1/op2/opcode control word. On `start`, the block replays entries `0..ctx_last` once per iteration, repeats for `iter_count` iterations, then pulses `done`. It sits between the configuration bus and the PE array and is the only source of PE control words during a run.

## Interface
- `CTRL_WIDTH`, default 10: context word width. Must match the PE `ctrl_width`.
- `DEPTH`, default 16: number of context entries. Power of two, ≥2.
- `ITER_WIDTH`, default 8: width of the iteration counter.
- `AW`, default `$clog2(DEPTH)`: context address width. Derived; do not override.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_we`  in  1: context write strobe.
- `cfg_addr`  in  AW: context write address.
- `cfg_data`  in  CTRL_WIDTH: context write data.
- `cfg_rej`  out  1: one-cycle pulse when a `cfg_we` is ignored because the block is busy.
- `start`  in  1: begin a run. Sampled only in IDLE.
- `ctx_last`  in  AW: index of the last context entry. Latched at start.
- `iter_count`  in  ITER_WIDTH: number of iterations. Latched at start.
- `stall`  in  1: back-pressure from the array. While high, no word is issued.
- `ctrl_out`  out  CTRL_WIDTH: registered control word to the PE.
- `ctrl_valid`  out  1: `ctrl_out` is a freshly issued word this cycle.
- `iter_idx`  out  ITER_WIDTH: current iteration number, zero-based.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse at the end of a run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `cfg_we` writes `mem[cfg_addr] <= cfg_data`.
  - On `start`, latch `ctx_last` and `iter_count`, clear `pc` and `iter_idx`.
  - If the latched `iter_count == 0`, go to DONE. Otherwise go to RUN.
- RUN, each edge with `!stall`:
  - `ctrl_out <= mem[pc]`, `ctrl_valid <= 1`.
  - If `pc != ctx_last`: `pc <= pc+1`.
  - Else if `iter_idx == iter_count-1`: go to DONE.
  - Else: `pc <= 0` and `iter_idx <= iter_idx+1`.
- RUN, edge with `stall`:
  - `ctrl_valid <= 0`; `ctrl_out`, `pc` and `iter_idx` hold.
  - No word is skipped or duplicated.
- DONE: `done = 1` and `ctrl_valid <= 0` for exactly one cycle, then go to IDLE.
- Words issued per run = `(ctx_last+1)*iter_count`.
- `ctx_last = 0` is legal: the same entry is issued once per iteration.
- `cfg_we` while busy: the write is dropped, memory is unchanged, and `cfg_rej` pulses on the next cycle.
- `start` while busy is ignored, with no error.
- A `start` in the same cycle as `cfg_we` in IDLE: the write completes. A run may read that entry only from the cycle after the write.
- Counters: `pc` wraps only through `ctx_last`, never past `DEPTH-1`. `iter_idx` never exceeds `iter_count-1`.

## Timing
- Reset values:
  - State is IDLE.
  - `ctrl_out`, `ctrl_valid`, `iter_idx`, `busy`, `done` and `cfg_rej` are 0.
  - Context memory is not reset.
- Run start: `start` is sampled at edge E0. `busy` is 1 after E0. The first `ctrl_valid`, carrying `mem[0]`, appears after E1, assuming no stall.
- Throughput: one word per unstalled cycle.
- Stall latency: the stall applies at the edge where it is sampled. The word issued at the next unstalled edge is the one that was pending.
- Run end: the last word is valid for one cycle. `done` pulses in the following cycle, and `busy` drops together with `done`.
- `iter_count = 0`: `done` pulses in the cycle after E0 and no `ctrl_valid` is issued.
- Reset mid-run: after the reset edge the block is in IDLE with all outputs 0 and no `done` pulse. Context contents are retained.

## Structure
- Shared package `pe_pkg`:
  - `seq_state_t` enum (IDLE/RUN/DONE).
  - Default `CTRL_WIDTH` and data widths.
  - PE control-field slice positions (output, op1, op2, opcode).
  - Opcode and port-select constants (ADD/SUB/MUL/DIV; E/S/W/N/REG1/REG2/MEM).
- One sub-module, `pe_ctx_mem`: `DEPTH`×`CTRL_WIDTH`, one synchronous write port, one combinational read port addressed by `pc`.

## Test plan
- Load entries 0..3 = 0x001, 0x002, 0x003, 0x004; `ctx_last = 3`, `iter_count = 2`, no stall → 8 consecutive valid words 1,2,3,4,1,2,3,4; `iter_idx` reads 0×4 then 1×4; `done` pulses one cycle after the last word.
- Same setup, with `stall` held high for 3 cycles after the 2nd word → the sequence is unchanged, `ctrl_valid` is low for those 3 cycles, `ctrl_out` holds 0x002, and the next valid word is 0x003.
- `iter_count = 0` with `start` → `busy` is high for 1 cycle, `done` pulses in the cycle after `start`, and `ctrl_valid` never asserts.
- During a run, `cfg_we` to addr 1 with 0x3FF → `cfg_rej` pulses; after the run, a rerun still emits 0x002 at entry 1.
- `ctx_last = 0`, `iter_count = 5`, `mem[0] = 0x155` → 5 valid 0x155 words and `iter_idx` 0..4; a second `start` issued mid-run is ignored.
- Assert `rst` after the 3rd word of an 8-word run → all outputs are 0 on the next cycle, there is no `done`, and a fresh `start` replays from entry 0 with the memory intact.
